dcache_line_memory: RTL and testbench
=====================================

// Module: dcache_line_memory
// PURPOSE
//  Line-granular main data memory answering dcache miss traffic: one 256-bit line per request.
//  Latches a request on mem_enable, waits a fixed access latency, then returns a 1-cycle ack
//  (with read data on reads, committing the line on writes). Sits below dcache_top on the mem_* bus.
// PARAMETERS
//  LATENCY     10   cycles from request capture to ack edge; legal range 1..255
//  DEPTH_LOG2  9    log2 of line count (default 512 lines = 16 KiB)
// PORTS
//  clk_i      in   1    clock, rising edge
//  rst_i      in   1    asynchronous, active-low reset
//  enable_i   in   1    request valid (held by cache until ack)
//  write_i    in   1    1 = write line, 0 = read line; sampled with enable_i
//  addr_i     in   32   byte address; line index = addr_i[DEPTH_LOG2+4:5], addr_i[4:0] ignored
//  data_i     in   256  write line, sampled with enable_i
//  ack_o      out  1    one-cycle completion pulse
//  data_o     out  256  read line, valid while ack_o=1 after a read
//  err_o      out  1    out-of-range flag, valid with ack_o (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, ack_o=0, data_o=0, err_o=0, latched req regs=0. Array NOT cleared.
//  FSM states: IDLE, BUSY, ACK.
//   IDLE: enable_i=1 at edge E0 -> latch write_i/addr_i/data_i, cnt=LATENCY-1; go BUSY
//         (LATENCY=1: go straight to ACK work at E0+1). enable_i=0 -> stay IDLE.
//   BUSY: cnt!=0 -> cnt-1. cnt==0 at edge -> perform access, ack_o<=1, go ACK.
//   ACK : ack_o<=0, data_o holds, go IDLE. enable_i ignored in ACK.
//  Timing: ack_o high exactly during cycle [E0+LATENCY, E0+LATENCY+1); never two
//   consecutive ack cycles. Back-to-back: a request present in the cycle after ack is
//   captured at the following edge (IDLE), so next ack at E1+LATENCY.
//  Access at the ack-raising edge: write -> mem[idx]<=latched data, data_o unchanged;
//   read -> data_o<=mem[idx]. Read after completed write to same line returns new data.
//  Inputs are don't-care after capture: enable_i/addr_i/data_i changes during BUSY do not
//   abort or alter the request; enable_i dropped mid-request still yields ack.
//  Request arriving while BUSY/ACK is not queued; cache protocol keeps enable_i high, so
//   it is captured on return to IDLE.
//  Reset mid-request: pending write discarded (array untouched), no ack, outputs to reset values.
//  addr_i bits above DEPTH_LOG2+4: wrap (ignored) unless range check compiled in.
//  cnt width 8 bits; LATENCY outside 1..255 is a configuration error ($error at elaboration).
// CONFIGURATION
//  DCACHE_LINE_MEMORY_RANGE_CHECK_EN defined: if any addr_i[31:DEPTH_LOG2+5] bit set at
//   capture, request still takes LATENCY cycles and acks, but write is dropped, read
//   returns data_o=0, and err_o=1 for the ack cycle only.
//  Not defined: upper bits ignored (address wraps modulo line count); err_o tied 0.
// TESTING
//  1 reset: rst_i=0 mid-BUSY of a write to line 3 -> ack_o/data_o/err_o=0, line 3 unchanged.
//  2 write then read: write 0xA5..A5 to addr 0x0000_0060, then read same -> each ack exactly
//    10 cycles after capture, read data_o=0xA5..A5 in ack cycle.
//  3 writeback+refill: write addr 0x40 (enable held, write_i->0 after ack, addr->0x2040)
//    -> second request captured 2 edges after first ack, second ack 10 cycles later, one-cycle pulses.
//  4 LATENCY=1: read captured at E0 -> ack_o high in cycle after E0, then low.
//  5 input churn: change addr_i/data_i/enable_i=0 during BUSY -> original line accessed, ack delivered.
//  6 range: addr 0x8000_0020 write 0xFF..FF, then read 0x20 -> with _EN: err_o=1, line 1
//    unchanged; without: err_o=0, line 1 = 0xFF..FF (wrap).

Source files
------------

// File: rtl/dcache_line_memory.sv
// Line-granular backing memory for the dcache: one 256-bit line per request, fixed-latency ack.
// Define DCACHE_LINE_MEMORY_RANGE_CHECK_EN to flag and suppress out-of-range line accesses.
module dcache_line_memory #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         err_o
);

    localparam int unsigned LINES = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_e;

    if (LATENCY < 1 || LATENCY > 255) begin : g_latency_check
        $error("dcache_line_memory: LATENCY must be within 1..255");
    end

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [255:0]            wdata_q, wdata_d;
    logic                    rerr_q, rerr_d;
    logic                    ack_q, ack_d;
    logic [255:0]            rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [255:0]            mem_q [LINES];
    logic                    range_err;
    logic                    access;
    logic                    unused_addr;

`ifdef DCACHE_LINE_MEMORY_RANGE_CHECK_EN
    assign range_err = |addr_i[31:DEPTH_LOG2+5];
`else
    assign range_err = 1'b0;
`endif

    assign unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

    // The access edge is the one that raises ack.
    assign access = (state_q == BUSY) && (cnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rerr_d  = rerr_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = BUSY;
                    cnt_d   = 8'(LATENCY - 1);
                    write_d = write_i;
                    idx_d   = addr_i[DEPTH_LOG2+4:5];
                    wdata_d = data_i;
                    rerr_d  = range_err;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    err_d   = rerr_q;
                    if (!write_q) begin
                        rdata_d = rerr_q ? '0 : mem_q[idx_q];
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rerr_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rerr_q  <= rerr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; a reset mid-request leaves BUSY before access.
    always_ff @(posedge clk_i) begin
        if (access && write_q && !rerr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_dcache_line_memory.sv
// Bench for dcache_line_memory: timestamp model of the LATENCY=10 instance plus
// directed literal checks, including a LATENCY=1 instance.
module tb_dcache_line_memory;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, we = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] din = '0;
    logic         ack;
    logic [255:0] dout;
    logic         err;

    logic         en2 = 1'b0, we2 = 1'b0;
    logic [31:0]  addr2 = '0;
    logic [255:0] din2 = '0;
    logic         ack2;
    logic [255:0] dout2;
    logic         err2;

    int n_chk = 0;
    int n_err = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    dcache_line_memory #(.LATENCY(LAT), .DEPTH_LOG2(9)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en), .write_i(we),
        .addr_i(addr), .data_i(din), .ack_o(ack), .data_o(dout), .err_o(err)
    );

    dcache_line_memory #(.LATENCY(1), .DEPTH_LOG2(9)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en2), .write_i(we2),
        .addr_i(addr2), .data_i(din2), .ack_o(ack2), .data_o(dout2), .err_o(err2)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: a captured request acks exactly LAT edges later; the next capture
    // is allowed two edges after the ack edge.
    logic [255:0] mmem [int];
    int unsigned  cyc = 0;
    int unsigned  idle_from = 0;
    int unsigned  p_ack_at = 0;
    bit           p_valid = 0, p_write = 0, p_err = 0;
    int           p_idx = 0;
    logic [255:0] p_data = '0;
    logic         e_ack = 0, e_err = 0;
    logic [255:0] e_data = '0;
    bit           e_dvld = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ack = 0; e_err = 0; e_data = '0; e_dvld = 1;
            p_valid = 0; idle_from = 0;
        end else begin
            cyc = cyc + 1;
            e_ack = 0;
            e_err = 0;
            if (p_valid && cyc == p_ack_at) begin
                e_ack = 1;
                e_err = p_err;
                p_valid = 0;
                idle_from = cyc + 2;
                if (p_write) begin
                    if (!p_err) mmem[p_idx] = p_data;
                end else if (p_err) begin
                    e_data = '0; e_dvld = 1;
                end else if (mmem.exists(p_idx)) begin
                    e_data = mmem[p_idx]; e_dvld = 1;
                end else begin
                    e_dvld = 0;
                end
            end else if (!p_valid && cyc >= idle_from && en) begin
                p_valid = 1;
                p_write = we;
                p_idx = int'((addr / 32) % 512);
                p_data = din;
`ifdef DCACHE_LINE_MEMORY_RANGE_CHECK_EN
                p_err = (addr >= 32'h0000_4000);
`else
                p_err = 0;
`endif
                p_ack_at = cyc + LAT;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model ack", {255'd0, ack}, {255'd0, e_ack});
            chk("model err", {255'd0, err}, {255'd0, e_err});
            if (e_dvld) chk("model data", dout, e_data);
        end
    end

    task automatic wait_ack(output int n);
        n = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            if (ack) break;
            if (n >= 60) begin
                n_chk++; n_err++;
                $display("FAIL ack timeout: got no ack after %0d cycles, required one", n);
                break;
            end
        end
    endtask

    task automatic req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                       output int lat);
        @(posedge clk); #1;
        en = 1; we = wr; addr = a; din = d;
        @(posedge clk); #1;
        en = 0;
        wait_ack(lat);
    endtask

    int lat;
    logic [255:0] exp_l1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", {255'd0, ack}, 256'd0);
        chk("reset data", dout, 256'd0);
        chk("reset err", {255'd0, err}, 256'd0);
        rst_n = 1;
        started = 1;

        // reset mid-request discards the pending write
        req(1, 32'h60, {32{8'h33}}, lat);
        chk("wr3 latency", 256'(lat), 256'd10);
        @(posedge clk); #1;
        en = 1; we = 1; addr = 32'h60; din = {32{8'hCC}};
        @(posedge clk); #1;
        en = 0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("midrst ack", {255'd0, ack}, 256'd0);
        chk("midrst data", dout, 256'd0);
        chk("midrst err", {255'd0, err}, 256'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        req(0, 32'h60, '0, lat);
        chk("line3 kept", dout, {32{8'h33}});

        // write then read
        req(1, 32'h60, {32{8'hA5}}, lat);
        chk("wrA5 latency", 256'(lat), 256'd10);
        req(0, 32'h60, '0, lat);
        chk("rdA5 latency", 256'(lat), 256'd10);
        chk("rdA5 data", dout, {32{8'hA5}});

        // writeback then refill with enable held
        req(1, 32'h2040, {32{8'h77}}, lat);
        @(posedge clk); #1;
        en = 1; we = 1; addr = 32'h40; din = {32{8'h44}};
        @(posedge clk); #1;
        wait_ack(lat);
        chk("wb latency", 256'(lat), 256'd10);
        we = 0; addr = 32'h2040;
        @(posedge clk); #1;
        chk("wb pulse", {255'd0, ack}, 256'd0);
        wait_ack(lat);
        chk("refill gap", 256'(lat + 1), 256'd12);
        chk("refill data", dout, {32{8'h77}});
        en = 0;
        @(posedge clk); #1;
        chk("refill pulse", {255'd0, ack}, 256'd0);

        // LATENCY=1 instance
        en2 = 1; we2 = 1; addr2 = 32'h40; din2 = {32{8'h5A}};
        @(posedge clk); #1;
        en2 = 0;
        chk("l1 wr pre", {255'd0, ack2}, 256'd0);
        @(posedge clk); #1;
        chk("l1 wr ack", {255'd0, ack2}, 256'd1);
        @(posedge clk); #1;
        chk("l1 wr drop", {255'd0, ack2}, 256'd0);
        en2 = 1; we2 = 0;
        @(posedge clk); #1;
        en2 = 0;
        chk("l1 rd pre", {255'd0, ack2}, 256'd0);
        @(posedge clk); #1;
        chk("l1 rd ack", {255'd0, ack2}, 256'd1);
        chk("l1 rd data", dout2, {32{8'h5A}});
        @(posedge clk); #1;
        chk("l1 rd drop", {255'd0, ack2}, 256'd0);

        // input churn during BUSY
        @(posedge clk); #1;
        en = 1; we = 1; addr = 32'hA0; din = {32{8'hD5}};
        @(posedge clk); #1;
        en = 0; we = 0; addr = 32'h60; din = '0;
        wait_ack(lat);
        chk("churn latency", 256'(lat), 256'd10);
        req(0, 32'hA0, '0, lat);
        chk("churn line5", dout, {32{8'hD5}});
        req(0, 32'h60, '0, lat);
        chk("churn line3", dout, {32{8'hA5}});

        // out-of-range address
        req(1, 32'h20, {32{8'h11}}, lat);
        req(1, 32'h8000_0020, {32{8'hFF}}, lat);
`ifdef DCACHE_LINE_MEMORY_RANGE_CHECK_EN
        chk("range err", {255'd0, err}, 256'd1);
        exp_l1 = {32{8'h11}};
`else
        chk("range err", {255'd0, err}, 256'd0);
        exp_l1 = {32{8'hFF}};
`endif
        @(posedge clk); #1;
        chk("range err drop", {255'd0, err}, 256'd0);
        req(0, 32'h20, '0, lat);
        chk("range line1", dout, exp_l1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
